instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Producer side of the instruction decoder interface.
- Fetches variable-length instructions (1–3 bytes) from program memory one byte per handshake.
- Assembles opcode plus operand bytes and presents the complete instruction to decode/execute with a valid/ready handshake.
- Handles PC redirects (branch/jump/call/ret) and self-halts on HLT (0xF0).

Parameters:
- ADDR_WIDTH, 16, width of program counter and memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  byte read request.
- mem_addr  out  ADDR_WIDTH  byte address; stable while mem_req is high.
- mem_ack  in  1  request accepted; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  read data.
- instr_valid  out  1  assembled instruction is available.
- instr_ready  in  1  consumer accepts; transfer occurs when valid & ready.
- instruction  out  8  opcode byte.
- operand1  out  8  second byte; 0 if absent.
- operand2  out  8  third byte; 0 if absent.
- instr_length  out  2  1, 2 or 3.
- instr_pc  out  ADDR_WIDTH  address of the opcode byte.
- redirect  in  1  load a new PC and flush.
- redirect_pc  in  ADDR_WIDTH  target address.
- halted  out  1  fetch stopped after issuing HLT.

Behaviour:
- Reset (asynchronous) values:
  - pc = RESET_PC; state = FETCH_OP.
  - All outputs 0, except instr_length = 1.
- States:
  - FETCH_OP: mem_req = 1, mem_addr = pc. On mem_ack:
    - Latch opcode into instruction; instr_pc = pc; pc += 1.
    - Compute length (see length decode below); clear operand1 and operand2.
    - Go to FETCH_B1 if length > 1, else ISSUE.
  - FETCH_B1: mem_req = 1, addr = pc. On ack: operand1 = rdata; pc += 1. Go to FETCH_B2 if length = 3, else ISSUE.
  - FETCH_B2: on ack: operand2 = rdata; pc += 1; go to ISSUE.
  - ISSUE: instr_valid = 1; all instruction fields held stable. On instr_ready:
    - Go to HALTED if instruction = 0xF0, else FETCH_OP.
    - No bubble is required beyond that next state.
  - HALTED: mem_req = 0, halted = 1. Leaves only on redirect or rst.
- Length decode, from opcode op (hi = op[7:4]):
  - op = 0x20 → 3.
  - op = 0x21 → 2.
  - hi = 0xA → 2.
  - op ∈ {0xF1, 0xF3} → 2.
  - op ∈ {0xF8, 0xF9, 0xFA} → 3.
  - All others → 1.
- Latency: a 1-byte instruction with mem_ack always high appears as instr_valid one cycle after the opcode ack. A 3-byte instruction issues 3 cycles after its first request.
- mem_req and mem_addr are registered outputs. mem_req stays high and the address stays fixed until ack; the block never withdraws a request except on redirect.
- Redirect (any state, including ISSUE and HALTED) has priority over everything in the same cycle:
  - Next cycle: pc = redirect_pc, state = FETCH_OP, instr_valid = 0, halted = 0.
  - A mem_ack or instr_ready coinciding with redirect is ignored: data is discarded and no transfer is counted.
- PC arithmetic is modulo 2^ADDR_WIDTH. From 0xFFFF it wraps to 0x0000 mid-instruction; operand bytes come from 0x0000 onward.
- Backpressure: while in ISSUE with instr_ready = 0, no memory requests are issued (single-instruction buffer).
- rst asserted mid-instruction discards all partial state immediately.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants: OP_HLT 0xF0, OP_STA 0x20, OP_LDI 0xA?, OP_JZ_LONG 0xF8, OP_JMP_LONG 0xF9, OP_JNZ_LONG 0xFA, 0xF1, 0xF3, 0x21.
  - Fetch-state enum.
  - Function instr_len(op) → 2 bits. The decoder and this block both use it, so it must match the decoder's instr_length exactly.
- No sub-module; one sequential FSM with a datapath register set.

Test Plan:
1. Memory holds 0x10 at 0x0000, ack always high, ready high → instruction = 0x10, len 1, pc 0x0000, operands 0; next fetch at 0x0001.
2. Memory holds 0xF9,0x34,0x12 at 0x0010 → one issue: instruction 0xF9, operand1 0x34, operand2 0x12, len 3, instr_pc 0x0010. Next mem_addr is 0x0013.
3. Hold instr_ready = 0 for 5 cycles during ISSUE on 0xA5,0x07 → fields stable, mem_req = 0 throughout; transfer on the first ready cycle.
4. Assert redirect to 0x0200 while in FETCH_B1 of 0x21 → next cycle mem_addr = 0x0200, instr_valid never raised for the 0x21.
5. Fetch 0xF0 with ready high → issued once, then halted = 1 and mem_req = 0 indefinitely. Redirect to 0x0040 then resumes fetch at 0x0040.
6. Opcode 0x20 at 0xFFFF → operands read from 0x0000 and 0x0001; instr_pc 0xFFFF; next fetch at 0x0002. Random mem_ack stalls must give identical results.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM states, instruction length decode.
// Pure declarations, no logic latency.
// No flow control; consumed by the fetch unit and the decoder.
package cpu_pkg;

   localparam logic [7:0] OP_HLT      = 8'hF0;
   localparam logic [7:0] OP_STA      = 8'h20;
   localparam logic [7:0] OP_LD_IND   = 8'h21;
   localparam logic [3:0] OP_LDI_HI   = 4'hA;
   localparam logic [7:0] OP_OUT      = 8'hF1;
   localparam logic [7:0] OP_IN       = 8'hF3;
   localparam logic [7:0] OP_JZ_LONG  = 8'hF8;
   localparam logic [7:0] OP_JMP_LONG = 8'hF9;
   localparam logic [7:0] OP_JNZ_LONG = 8'hFA;

   typedef enum logic [2:0] {
      FETCH_OP = 3'd0,
      FETCH_B1 = 3'd1,
      FETCH_B2 = 3'd2,
      ISSUE    = 3'd3,
      HALTED   = 3'd4
   } fetch_state_t;

   // Total instruction length in bytes (1..3) from the opcode; must stay identical
   // to the decoder's view of instruction length.
   function automatic logic [1:0] instr_len(input logic [7:0] op);
      logic [1:0] len;
      len = 2'd1;
      if (op == OP_STA)
         len = 2'd3;
      else if (op == OP_LD_IND)
         len = 2'd2;
      else if (op[7:4] == OP_LDI_HI)
         len = 2'd2;
      else if (op == OP_OUT || op == OP_IN)
         len = 2'd2;
      else if (op == OP_JZ_LONG || op == OP_JMP_LONG || op == OP_JNZ_LONG)
         len = 2'd3;
      return len;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetches 1-3 byte instructions bytewise from program memory and issues them to decode.
// Latency: instr_valid one cycle after the last byte's ack (3 cycles after first request for 3-byte ops).
// Backpressure: single-instruction buffer; no memory requests while an issued instruction waits for instr_ready.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int               ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [7:0]            mem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [7:0]            instruction,
   output logic [7:0]            operand1,
   output logic [7:0]            operand2,
   output logic [1:0]            instr_length,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  halted
);

   fetch_state_t          state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [1:0]            op_len;
   logic                  byte_taken;

   // PC wraps naturally at 2^ADDR_WIDTH
   assign pc_inc     = pc + ADDR_WIDTH'(1);
   assign op_len     = instr_len(mem_rdata);
   assign byte_taken = mem_req && mem_ack;

   // Fetch FSM and datapath; redirect overrides every state and discards a coincident ack/ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= FETCH_OP;
         pc           <= RESET_PC;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         instr_valid  <= 1'b0;
         instruction  <= 8'h00;
         operand1     <= 8'h00;
         operand2     <= 8'h00;
         instr_length <= 2'd1;
         instr_pc     <= '0;
         halted       <= 1'b0;
      end else if (redirect) begin
         state       <= FETCH_OP;
         pc          <= redirect_pc;
         mem_req     <= 1'b1;
         mem_addr    <= redirect_pc;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            FETCH_OP: begin
               if (byte_taken) begin
                  instruction  <= mem_rdata;
                  instr_pc     <= pc;
                  pc           <= pc_inc;
                  instr_length <= op_len;
                  operand1     <= 8'h00;
                  operand2     <= 8'h00;
                  if (op_len > 2'd1) begin
                     state    <= FETCH_B1;
                     mem_addr <= pc_inc;
                  end else begin
                     state       <= ISSUE;
                     mem_req     <= 1'b0;
                     instr_valid <= 1'b1;
                  end
               end else begin
                  // Covers the first cycle after reset, when no request is yet outstanding
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end
            end
            FETCH_B1: begin
               if (byte_taken) begin
                  operand1 <= mem_rdata;
                  pc       <= pc_inc;
                  if (instr_length == 2'd3) begin
                     state    <= FETCH_B2;
                     mem_addr <= pc_inc;
                  end else begin
                     state       <= ISSUE;
                     mem_req     <= 1'b0;
                     instr_valid <= 1'b1;
                  end
               end
            end
            FETCH_B2: begin
               if (byte_taken) begin
                  operand2    <= mem_rdata;
                  pc          <= pc_inc;
                  state       <= ISSUE;
                  mem_req     <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            ISSUE: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (instruction == OP_HLT) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else begin
                     state    <= FETCH_OP;
                     mem_req  <= 1'b1;
                     mem_addr <= pc;
                  end
               end
            end
            HALTED: begin
               mem_req <= 1'b0;
               halted  <= 1'b1;
            end
            default: begin
               state   <= FETCH_OP;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a byte-array program memory.
// Memory answers combinationally; ack is either constant or randomly stalled.
// Issued instructions are logged at the falling edge and checked against hand values.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instruction;
   logic [7:0]  operand1;
   logic [7:0]  operand2;
   logic [1:0]  instr_length;
   logic [15:0] instr_pc;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halted;

   logic [7:0] mem [0:65535];
   logic       ack_fix;
   logic       ack_rnd;
   logic       rand_ack;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  ins;
      logic [7:0]  op1;
      logic [7:0]  op2;
      logic [1:0]  len;
      logic [15:0] pc;
   } xfer_t;

   xfer_t xfer_q[$];

   instruction_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instruction  (instruction),
      .operand1     (operand1),
      .operand2     (operand2),
      .instr_length (instr_length),
      .instr_pc     (instr_pc),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .halted       (halted)
   );

   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = rand_ack ? ack_rnd : ack_fix;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Random ack source, updated just after each rising edge
   initial begin
      ack_rnd = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ack_rnd = 1'($urandom_range(0, 1));
      end
   end

   // Log every accepted transfer; inputs only change just after rising edges
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready && !redirect)
         xfer_q.push_back('{ins: instruction, op1: operand1, op2: operand2,
                            len: instr_length, pc: instr_pc});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_xfer(input int target, input int budget);
      int n;
      n = 0;
      while (xfer_q.size() < target && n < budget) begin
         tick();
         n++;
      end
      chk("wait_xfer_count", xfer_q.size(), target);
   endtask

   task automatic do_redirect(input logic [15:0] tgt);
      redirect    = 1'b1;
      redirect_pc = tgt;
      tick();
      redirect    = 1'b0;
   endtask

   task automatic chk_xfer(input string tag, input int idx, input logic [7:0] ins,
                           input logic [7:0] op1, input logic [7:0] op2,
                           input logic [1:0] len, input logic [15:0] pc);
      xfer_t x;
      if (idx >= xfer_q.size()) begin
         chk({tag, "_present"}, xfer_q.size(), idx + 1);
      end else begin
         x = xfer_q[idx];
         chk({tag, "_ins"}, x.ins, ins);
         chk({tag, "_op1"}, x.op1, op1);
         chk({tag, "_op2"}, x.op2, op2);
         chk({tag, "_len"}, x.len, len);
         chk({tag, "_pc"},  x.pc,  pc);
      end
   endtask

   initial begin
      int n;
      logic found21;

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0000] = 8'h10;
      mem[16'h0001] = 8'h55;
      mem[16'h0010] = 8'hF9; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
      mem[16'h0013] = 8'hA5; mem[16'h0014] = 8'h07;
      mem[16'h0015] = 8'h21; mem[16'h0016] = 8'h99;
      mem[16'h0200] = 8'hF0;
      mem[16'h0040] = 8'h10;
      mem[16'hFFFF] = 8'h20;

      rst         = 1'b0;
      ack_fix     = 1'b1;
      rand_ack    = 1'b0;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;

      // Reset values
      #2 rst = 1'b1;
      #1;
      chk("rst_mem_req",  mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_valid",    instr_valid, 0);
      chk("rst_len",      instr_length, 1);
      chk("rst_halted",   halted, 0);
      chk("rst_instr",    instruction, 0);
      tick();
      rst = 1'b0;

      // 1: single-byte opcode at 0x0000
      wait_xfer(1, 20);
      chk_xfer("t1", 0, 8'h10, 8'h00, 8'h00, 2'd1, 16'h0000);
      chk("t1_next_req",  mem_req, 1);
      chk("t1_next_addr", mem_addr, 16'h0001);

      // 2: three-byte jump at 0x0010, issue exactly 3 cycles after the first request
      do_redirect(16'h0010);
      chk("t2_req_addr", mem_addr, 16'h0010);
      tick();
      tick();
      chk("t2_valid_early", instr_valid, 0);
      tick();
      chk("t2_valid_cyc3", instr_valid, 1);
      tick();
      chk("t2_count", xfer_q.size(), 2);
      chk_xfer("t2", 1, 8'hF9, 8'h34, 8'h12, 2'd3, 16'h0010);
      chk("t2_next_addr", mem_addr, 16'h0013);

      // 3: backpressure on 0xA5 0x07 for 5 cycles
      instr_ready = 1'b0;
      n = 0;
      while (!instr_valid && n < 10) begin
         tick();
         n++;
      end
      chk("t3_valid", instr_valid, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_req",   mem_req, 0);
         chk("t3_hold_valid", instr_valid, 1);
         chk("t3_hold_ins",   instruction, 8'hA5);
         chk("t3_hold_op1",   operand1, 8'h07);
      end
      chk("t3_no_xfer", xfer_q.size(), 2);
      instr_ready = 1'b1;
      tick();
      chk("t3_count", xfer_q.size(), 3);
      chk_xfer("t3", 2, 8'hA5, 8'h07, 8'h00, 2'd2, 16'h0013);
      chk("t3_next_addr", mem_addr, 16'h0015);

      // 4: redirect while fetching the operand of 0x21
      tick();
      chk("t4_in_b1_addr", mem_addr, 16'h0016);
      do_redirect(16'h0200);
      chk("t4_redir_addr",  mem_addr, 16'h0200);
      chk("t4_redir_req",   mem_req, 1);
      chk("t4_redir_valid", instr_valid, 0);

      // 5: HLT issues once, then fetch stops until redirected
      wait_xfer(4, 20);
      chk_xfer("t5", 3, 8'hF0, 8'h00, 8'h00, 2'd1, 16'h0200);
      chk("t5_halted", halted, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t5_idle_req",    mem_req, 0);
         chk("t5_idle_halted", halted, 1);
      end
      chk("t5_single_issue", xfer_q.size(), 4);
      do_redirect(16'h0040);
      chk("t5_resume_halted", halted, 0);
      chk("t5_resume_addr",   mem_addr, 16'h0040);
      wait_xfer(5, 20);
      chk_xfer("t5r", 4, 8'h10, 8'h00, 8'h00, 2'd1, 16'h0040);

      // 6: PC wrap from 0xFFFF with ack always high, then with random stalls
      do_redirect(16'hFFFF);
      wait_xfer(6, 20);
      chk_xfer("t6", 5, 8'h20, 8'h10, 8'h55, 2'd3, 16'hFFFF);
      chk("t6_next_addr", mem_addr, 16'h0002);

      rand_ack = 1'b1;
      do_redirect(16'hFFFF);
      wait_xfer(7, 200);
      chk_xfer("t6r", 6, 8'h20, 8'h10, 8'h55, 2'd3, 16'hFFFF);
      chk("t6r_next_addr", mem_addr, 16'h0002);
      rand_ack = 1'b0;

      found21 = 1'b0;
      foreach (xfer_q[i]) if (xfer_q[i].ins == 8'h21) found21 = 1'b1;
      chk("t4_no_issue_21", found21, 0);

      // Reset mid-instruction drops partial state immediately
      do_redirect(16'h0010);
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_req",   mem_req, 0);
      chk("rst_mid_ins",   instruction, 0);
      chk("rst_mid_len",   instr_length, 1);
      chk("rst_mid_pc",    instr_pc, 0);
      tick();
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
